// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned per operation.
// Operands are reduced to magnitudes and the results are sign-corrected.
// Handshake: start (sampled while idle) / busy / one-cycle done pulse.
// Optional build macro DIV_EARLY_EXIT_EN: skip the DIV phase when |dividend| < |divisor|.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic             dz_q, dz_d;

    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic             a_neg_c, b_neg_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic             div_zero_c;
    logic             early_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH+1:0] trial_c;

    // Operand magnitudes and signs as seen at start.
    always_comb begin
        a_neg_c    = signed_mode & dividend[WIDTH-1];
        b_neg_c    = signed_mode & divisor[WIDTH-1];
        mag_a_c    = a_neg_c ? WIDTH'(-dividend) : dividend;
        mag_b_c    = b_neg_c ? WIDTH'(-divisor)  : divisor;
        div_zero_c = (divisor == '0);
    end

`ifdef DIV_EARLY_EXIT_EN
    assign early_c = !div_zero_c && (mag_a_c < mag_b_c);
`else
    assign early_c = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted_c = {rem_q, quo_q[WIDTH-1]};
        trial_c   = {1'b0, shifted_c} - {2'b00, dvs_q};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (div_zero_c || early_c) ? ST_FIX : ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        rem_d         = rem_q;
        quo_d         = quo_q;
        dvs_d         = dvs_q;
        cnt_d         = cnt_q;
        qsign_d       = qsign_q;
        rsign_d       = rsign_q;
        dz_d          = dz_q;
        busy_d        = (state_d != ST_IDLE);
        done_d        = 1'b0;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dvs_d   = mag_b_c;
                    qsign_d = a_neg_c ^ b_neg_c;
                    rsign_d = a_neg_c;
                    dz_d    = div_zero_c;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    if (div_zero_c || early_c) begin
                        rem_d = mag_a_c;
                        quo_d = '0;
                    end else begin
                        rem_d = '0;
                        quo_d = mag_a_c;
                    end
                end
            end
            ST_DIV: begin
                if (trial_c[WIDTH+1]) begin
                    rem_d = shifted_c[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end else begin
                    rem_d = trial_c[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_FIX: begin
                done_d        = 1'b1;
                quotient_d    = dz_q ? '1 : (qsign_q ? WIDTH'(-quo_q) : quo_q);
                remainder_d   = rsign_q ? WIDTH'(-rem_q) : rem_q;
                div_by_zero_d = dz_q;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q         <= '0;
            quo_q         <= '0;
            dvs_q         <= '0;
            cnt_q         <= '0;
            qsign_q       <= 1'b0;
            rsign_q       <= 1'b0;
            dz_q          <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dvs_q         <= dvs_d;
            cnt_q         <= cnt_d;
            qsign_q       <= qsign_d;
            rsign_q       <= rsign_d;
            dz_q          <= dz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and randomized checks of seq_divider (WIDTH=16)
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned W = 16;
`ifdef DIV_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division; quotient truncates toward zero,
    // remainder takes the dividend's sign.
    task automatic model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat);
        longint sa, sb, ma, mb;
        if (b == '0) begin
            q = '1; r = a; dz = 1'b1; lat = 2;
        end else begin
            if (sm) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            dz = 1'b0;
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            lat = (EARLY && ma < mb) ? 2 : W + 2;
        end
    endtask

    // Pulses start in one cycle (cycle 0) and waits, bounded, for done.
    task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] q,
                         output logic [W-1:0] r, output logic dz);
        @(negedge clk);
        start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        q = quotient; r = remainder; dz = div_by_zero;
    endtask

    task automatic run_check(input string tag, input logic sm,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, elat;
        logic [W-1:0] q, r, eq, er;
        logic dz, edz;
        model(sm, a, b, eq, er, edz, elat);
        do_op(sm, a, b, lat, q, r, dz);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(q), 32'(eq));
        chk({tag, "_r"}, 32'(r), 32'(er));
        chk({tag, "_dz"}, 32'(dz), 32'(edz));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = W'(1);
            2:       v = '1;
            3:       v = W'(16'h8000);
            4:       v = W'($urandom_range(0, 15));
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        int lat, ndone, dcyc;
        logic [W-1:0] q, r, qv, rv;
        logic dz;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // 1. unsigned 100/7
        do_op(1'b0, 16'd100, 16'd7, lat, q, r, dz);
        chk("t1_lat", 32'(lat), 32'd18);
        chk("t1_q", 32'(q), 32'd14);
        chk("t1_r", 32'(r), 32'd2);
        chk("t1_dz", 32'(dz), 32'd0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        chk("t1_q_hold", 32'(quotient), 32'd14);

        // 2. signed sign handling
        do_op(1'b1, 16'hFF9C, 16'h0007, lat, q, r, dz);
        chk("t2a_q", 32'(q), 32'hFFF2);
        chk("t2a_r", 32'(r), 32'hFFFE);
        do_op(1'b1, 16'd100, 16'hFFF9, lat, q, r, dz);
        chk("t2b_q", 32'(q), 32'hFFF2);
        chk("t2b_r", 32'(r), 32'h0002);

        // 3. signed overflow and unsigned max
        do_op(1'b1, 16'h8000, 16'hFFFF, lat, q, r, dz);
        chk("t3a_q", 32'(q), 32'h8000);
        chk("t3a_r", 32'(r), 32'h0);
        chk("t3a_dz", 32'(dz), 32'd0);
        do_op(1'b0, 16'hFFFF, 16'h0001, lat, q, r, dz);
        chk("t3b_q", 32'(q), 32'hFFFF);
        chk("t3b_r", 32'(r), 32'h0);

        // 4. divide by zero, then flag clears
        do_op(1'b0, 16'd1234, 16'd0, lat, q, r, dz);
        chk("t4a_lat", 32'(lat), 32'd2);
        chk("t4a_q", 32'(q), 32'hFFFF);
        chk("t4a_r", 32'(r), 32'd1234);
        chk("t4a_dz", 32'(dz), 32'd1);
        do_op(1'b0, 16'd10, 16'd3, lat, q, r, dz);
        chk("t4b_q", 32'(q), 32'd3);
        chk("t4b_r", 32'(r), 32'd1);
        chk("t4b_dz", 32'(dz), 32'd0);
        do_op(1'b1, 16'hFF9C, 16'd0, lat, q, r, dz);
        chk("t4c_r", 32'(r), 32'hFF9C);

        // 5a. start while busy is ignored
        @(negedge clk);
        start = 1'b1; signed_mode = 1'b0; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; dcyc = 0; qv = '0; rv = '0;
        for (int c = 1; c <= 30; c++) begin
            if (done) begin
                ndone++;
                if (dcyc == 0) begin
                    dcyc = c; qv = quotient; rv = remainder;
                end
            end
            if (c == 5) begin
                start = 1'b1; dividend = 16'd50; divisor = 16'd5;
            end
            if (c == 6) start = 1'b0;
            @(posedge clk); #1;
        end
        chk("t5a_ndone", 32'(ndone), 32'd1);
        chk("t5a_lat", 32'(dcyc), 32'd18);
        chk("t5a_q", 32'(qv), 32'd333);
        chk("t5a_r", 32'(rv), 32'd1);

        // 5b. reset mid-operation aborts
        @(negedge clk);
        start = 1'b1; dividend = 16'd1000; divisor = 16'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) rst = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("t5b_busy_pre", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5b_busy", 32'(busy), 32'd0);
        chk("t5b_done", 32'(done), 32'd0);
        chk("t5b_q", 32'(quotient), 32'd0);
        chk("t5b_r", 32'(remainder), 32'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("t5b_no_done", 32'(ndone), 32'd0);

        // 6. small quotient, then back-to-back start in the done cycle
        do_op(1'b0, 16'd5, 16'd9, lat, q, r, dz);
        chk("t6_lat", 32'(lat), EARLY ? 32'd2 : 32'd18);
        chk("t6_q", 32'(q), 32'd0);
        chk("t6_r", 32'(r), 32'd5);
        run_check("t6_b2b", 1'b0, 16'd200, 16'd13);

        // randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            logic sm;
            logic [W-1:0] a, b;
            sm = 1'($urandom_range(0, 1));
            a  = pick();
            b  = pick();
            run_check($sformatf("rnd%0d", i), sm, a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
